jedro_1_ifu_pf: RTL and testbench



---
 rtl/jedro_1_ifu_pf_if.sv | 28 ++
 rtl/jedro_1_ifu_pf.sv | 178 +++++++++++++++++
 tb/tb_jedro_1_ifu_pf.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jedro_1_ifu_pf_if.sv
// Instruction memory bus between the jedro_1 prefetching fetch unit (master)
// and the instruction memory (slave): request channel plus response channel.
interface jedro_1_ifu_pf_if;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strobe;
  logic        req_write;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        rsp_valid;
  logic        rsp_ready;

  modport master (
    output req_addr, req_data, req_strobe, req_write, req_valid,
    input  req_ready,
    input  rsp_data, rsp_error, rsp_valid,
    output rsp_ready
  );

  modport slave (
    input  req_addr, req_data, req_strobe, req_write, req_valid,
    output req_ready,
    output rsp_data, rsp_error, rsp_valid,
    input  rsp_ready
  );
endinterface

// File: rtl/jedro_1_ifu_pf.sv
// Prefetching instruction fetch unit for jedro_1: up to MAX_OUTSTANDING reads in
// flight, FIFO_DEPTH-entry prefetch FIFO. Optional bus-error halt: JEDRO_1_IFU_BUS_ERR_EN.
module jedro_1_ifu_pf #(
  parameter logic [31:0] BOOT_ADDR       = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  jedro_1_ifu_pf_if.master instr_if,
  output logic [31:0]      dec_instr_o,
  output logic [31:0]      dec_pc_o,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  input  logic             jmp_addr_valid_i,
  input  logic [31:0]      jmp_addr_i,
  output logic             ctrl_insn_misalign_exception_o,
  output logic             ctrl_insn_access_fault_o,
  output logic [31:0]      ctrl_fault_addr_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   dec_pc_q, dec_pc_d;
  logic [31:0]   fault_addr_q, fault_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          misalign_q, misalign_d;
  logic          acc_fault_q, acc_fault_d;
  logic [31:0]   fifo_q [FIFO_DEPTH];

  logic        req_valid_s;
  logic        req_fire_s;
  logic        rsp_fire_s;
  logic        dec_fire_s;
  logic        push_s;
  logic        rsp_err_s;
  logic [31:0] credit_s;
  logic [31:0] tail_pc_s;

  // Outstanding requests that will still land in the FIFO, plus what is already queued.
  assign credit_s    = 32'(out_q) - 32'(drop_q) + 32'(cnt_q);
  assign req_valid_s = ~rst_i & (state_q == RUN) & ~jmp_addr_valid_i
                     & (32'(out_q) < MAX_OUTSTANDING) & (credit_s < FIFO_DEPTH);
  assign req_fire_s  = req_valid_s & instr_if.req_ready;
  assign rsp_fire_s  = instr_if.rsp_valid;
  assign dec_fire_s  = (cnt_q != {CW{1'b0}}) & dec_ready_i & ~jmp_addr_valid_i;
  // Next live response belongs to the instruction right behind the FIFO tail.
  assign tail_pc_s   = dec_pc_q + 32'({cnt_q, 2'b00});

`ifdef JEDRO_1_IFU_BUS_ERR_EN
  assign rsp_err_s = rsp_fire_s & (drop_q == {OW{1'b0}}) & instr_if.rsp_error;
`else
  logic unused_rsp_error_s;
  assign unused_rsp_error_s = instr_if.rsp_error;
  assign rsp_err_s          = 1'b0;
`endif

  assign push_s = rsp_fire_s & (drop_q == {OW{1'b0}}) & ~rsp_err_s & ~jmp_addr_valid_i;

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    dec_pc_d     = dec_pc_q;
    fault_addr_d = fault_addr_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    misalign_d   = 1'b0;
    acc_fault_d  = 1'b0;
    out_d        = out_q + OW'(req_fire_s) - OW'(rsp_fire_s);
    if (jmp_addr_valid_i) begin
      req_addr_d = jmp_addr_i;
      dec_pc_d   = jmp_addr_i;
      cnt_d      = {CW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      drop_d     = out_q - OW'(rsp_fire_s);
      if (jmp_addr_i[1:0] == 2'b00) begin
        state_d = RUN;
      end else begin
        state_d      = HALT;
        misalign_d   = 1'b1;
        fault_addr_d = jmp_addr_i;
      end
    end else begin
      if (req_fire_s) begin
        req_addr_d = req_addr_q + 32'd4;
      end else begin
        req_addr_d = req_addr_q;
      end
      if (rsp_fire_s && (drop_q != {OW{1'b0}})) begin
        drop_d = drop_q - OW'(1'b1);
      end else if (rsp_err_s) begin
        // Everything still in flight after this response is stale.
        drop_d       = out_d;
        state_d      = HALT;
        acc_fault_d  = 1'b1;
        fault_addr_d = tail_pc_s;
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (dec_fire_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
        dec_pc_d = dec_pc_q + 32'd4;
      end else begin
        rd_ptr_d = rd_ptr_q;
        dec_pc_d = dec_pc_q;
      end
      cnt_d = cnt_q + CW'(push_s) - CW'(dec_fire_s);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      req_addr_q   <= BOOT_ADDR;
      dec_pc_q     <= BOOT_ADDR;
      fault_addr_q <= 32'h0000_0000;
      cnt_q        <= {CW{1'b0}};
      out_q        <= {OW{1'b0}};
      drop_q       <= {OW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      misalign_q   <= 1'b0;
      acc_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      dec_pc_q     <= dec_pc_d;
      fault_addr_q <= fault_addr_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      drop_q       <= drop_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      misalign_q   <= misalign_d;
      acc_fault_q  <= acc_fault_d;
    end
  end

  // Prefetch storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= instr_if.rsp_data;
    end
  end

  assign instr_if.req_addr   = req_addr_q;
  assign instr_if.req_data   = 32'h0000_0000;
  assign instr_if.req_strobe = 4'b1111;
  assign instr_if.req_write  = 1'b0;
  assign instr_if.req_valid  = req_valid_s;
  assign instr_if.rsp_ready  = 1'b1;

  assign dec_instr_o                    = fifo_q[rd_ptr_q];
  assign dec_pc_o                       = dec_pc_q;
  assign dec_valid_o                    = (cnt_q != {CW{1'b0}});
  assign ctrl_insn_misalign_exception_o = misalign_q;
  assign ctrl_insn_access_fault_o       = acc_fault_q;
  assign ctrl_fault_addr_o              = fault_addr_q;

endmodule

// File: tb/tb_jedro_1_ifu_pf.sv
// Randomized bench for jedro_1_ifu_pf against an epoch-tagged transaction model
// of the fetch stream, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_jedro_1_ifu_pf;
  localparam logic [31:0] BOOT  = 32'h8000_0000;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
`ifdef JEDRO_1_IFU_BUS_ERR_EN
  localparam bit BUS_ERR_EN = 1'b1;
`else
  localparam bit BUS_ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jedro_1_ifu_pf_if bus ();
  logic [31:0] dec_instr, dec_pc, jmp_addr, fault_addr;
  logic        dec_valid, dec_ready, jmp_valid, misalign, acc_fault;

  jedro_1_ifu_pf #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .instr_if(bus),
    .dec_instr_o(dec_instr), .dec_pc_o(dec_pc), .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .jmp_addr_valid_i(jmp_valid), .jmp_addr_i(jmp_addr),
    .ctrl_insn_misalign_exception_o(misalign), .ctrl_insn_access_fault_o(acc_fault),
    .ctrl_fault_addr_o(fault_addr)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  mreq_t       memq[$];
  ent_t        expq[$];
  int          epoch, cyc, checks, errors;
  bit          halted, exp_mis, exp_acc;
  logic [31:0] m_req_addr, m_fault_addr;
  int          jmp_pct, rdy_pct, dec_pct, lat_min, lat_max, err_pct;
  bit          err_addr_en;
  logic [31:0] err_addr;
  bit          last_req_fire, last_dec_fire, obs_mis, obs_acc;
  logic [31:0] last_req_addr, last_dec_pc, last_dec_instr, obs_fault;
  int          n_req, n_dec;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'h8000_0000 + ($urandom_range(1023) << 2);
    if ($urandom_range(9) == 0) t[1:0] = 2'($urandom_range(3, 1));
    if ($urandom_range(24) == 0) t = 32'hFFFF_FFF0;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    jmp_valid = 1'b0; jmp_addr = 32'h0; dec_ready = 1'b0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = 32'h0; bus.rsp_error = 1'b0;
  endtask

  task automatic model_reset();
    memq.delete(); expq.delete();
    epoch = epoch + 1; halted = 1'b0; exp_mis = 1'b0; exp_acc = 1'b0;
    m_req_addr = BOOT; m_fault_addr = 32'h0;
  endtask

  // One clock: drive at negedge, compare and advance the model at negedge+1.
  task automatic step(input bit fj, input logic [31:0] fja);
    int    live, old_epoch;
    bit    req_f, dec_f, rsp_f, rsp_err, exp_rv;
    mreq_t r;
    @(negedge clk);
    if (fj) begin
      jmp_valid = 1'b1; jmp_addr = fja;
    end else if ($urandom_range(99) < jmp_pct) begin
      jmp_valid = 1'b1; jmp_addr = rand_target();
    end else begin
      jmp_valid = 1'b0; jmp_addr = $urandom;
    end
    dec_ready     = ($urandom_range(99) < dec_pct);
    bus.req_ready = ($urandom_range(99) < rdy_pct);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = memfn(memq[0].addr);
      bus.rsp_error = ($urandom_range(99) < err_pct) || (err_addr_en && memq[0].addr == err_addr);
    end else begin
      bus.rsp_valid = 1'b0; bus.rsp_data = $urandom; bus.rsp_error = 1'($urandom_range(1));
    end
    #1;
    live = 0;
    foreach (memq[i]) if (memq[i].epoch == epoch) live++;
    exp_rv = !halted && !jmp_valid && memq.size() < MAXO && (live + expq.size()) < DEPTH;
    check("req_valid", bus.req_valid, exp_rv);
    if (bus.req_valid) check("req_addr", bus.req_addr, m_req_addr);
    check("dec_valid", dec_valid, expq.size() != 0);
    if (expq.size() != 0) begin
      check("dec_pc", dec_pc, expq[0].pc);
      check("dec_instr", dec_instr, expq[0].data);
    end
    check("misalign_pulse", misalign, exp_mis);
    check("access_fault_pulse", acc_fault, exp_acc);
    check("fault_addr", fault_addr, m_fault_addr);
    obs_mis = misalign; obs_acc = acc_fault; obs_fault = fault_addr;

    req_f = bus.req_valid && bus.req_ready;
    dec_f = dec_valid && dec_ready && !jmp_valid;
    rsp_f = bus.rsp_valid;
    rsp_err = bus.rsp_error;
    last_req_fire = req_f; last_req_addr = bus.req_addr;
    last_dec_fire = dec_f; last_dec_pc = dec_pc; last_dec_instr = dec_instr;
    if (req_f) n_req++;
    if (dec_f) n_dec++;
    exp_mis = 1'b0; exp_acc = 1'b0;
    old_epoch = epoch;
    if (jmp_valid) begin
      expq.delete();
      epoch = epoch + 1;
      m_req_addr = jmp_addr;
      halted = (jmp_addr[1:0] != 2'b00);
      if (halted) begin exp_mis = 1'b1; m_fault_addr = jmp_addr; end
      if (rsp_f) r = memq.pop_front();
    end else begin
      if (dec_f) void'(expq.pop_front());
      if (rsp_f) begin
        r = memq.pop_front();
        if (r.epoch == epoch) begin
          if (BUS_ERR_EN && rsp_err) begin
            exp_acc = 1'b1; m_fault_addr = r.addr; halted = 1'b1; epoch = epoch + 1;
          end else begin
            expq.push_back('{r.addr, memfn(r.addr)});
          end
        end
      end
      if (req_f) begin
        memq.push_back('{bus.req_addr, old_epoch, cyc + $urandom_range(lat_max, lat_min)});
        m_req_addr = m_req_addr + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] rq[$], dq[$];
    int          dc[$];
    int          n0, k;
    bit          seen;
    checks = 0; errors = 0; cyc = 0; epoch = 0; n_req = 0; n_dec = 0;
    jmp_pct = 0; rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1; err_pct = 0;
    err_addr_en = 1'b0; err_addr = 32'h0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_dec_valid", dec_valid, 1'b0);
    check("rst_req_valid", bus.req_valid, 1'b0);
    check("rst_req_addr", bus.req_addr, 32'h8000_0000);
    check("rst_dec_pc", dec_pc, 32'h8000_0000);
    check("rst_pulses", {misalign, acc_fault}, 2'b00);
    check("rst_fault_addr", fault_addr, 32'h0);
    check("tied_ctrl", {bus.rsp_ready, bus.req_write, bus.req_strobe}, 6'b10_1111);
    check("tied_data", bus.req_data, 32'h0);
    model_reset();
    rst = 1'b0;

    // Streaming from boot with single-cycle memory.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0);
      if (last_req_fire) rq.push_back(last_req_addr);
      if (last_dec_fire) begin dq.push_back(last_dec_pc); dc.push_back(cyc); end
    end
    check("boot_req0", rq[0], 32'h8000_0000);
    check("boot_req1", rq[1], 32'h8000_0004);
    check("boot_req2", rq[2], 32'h8000_0008);
    check("boot_dec0", dq[0], 32'h8000_0000);
    check("boot_dec2", dq[2], 32'h8000_0008);
    check("boot_dec_gap", dc[2] - dc[0], 2);

    // Stalled decoder: FIFO fills with exactly DEPTH requests.
    dec_pct = 0;
    step(1'b1, 32'h8000_1000);
    n0 = n_req;
    repeat (12) step(1'b0, 32'h0);
    check("fill_req_count", n_req - n0, 4);
    check("fill_last_addr", bus.req_addr, 32'h8000_1010);
    dec_pct = 100; dq.delete();
    repeat (10) begin
      step(1'b0, 32'h0);
      if (last_dec_fire) dq.push_back(last_dec_pc);
    end
    check("drain_dec0", dq[0], 32'h8000_1000);
    check("drain_dec3", dq[3], 32'h8000_100C);

    // Three-cycle memory, jump with two requests in flight.
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h8000_0000);
    k = 0;
    while (memq.size() < 2 && k < 10) begin step(1'b0, 32'h0); k++; end
    check("inflight_two", memq.size(), 2);
    step(1'b1, 32'h8000_0100);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin step(1'b0, 32'h0); seen = last_dec_fire; k++; end
    check("jmp_first_seen", seen, 1'b1);
    check("jmp_first_pc", last_dec_pc, 32'h8000_0100);
    check("jmp_first_instr", last_dec_instr, memfn(32'h8000_0100));

    // Misaligned jump halts until an aligned jump.
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'h8000_0102);
    step(1'b0, 32'h0);
    check("mis_pulse", obs_mis, 1'b1);
    check("mis_fault_addr", obs_fault, 32'h8000_0102);
    n0 = n_req;
    repeat (6) step(1'b0, 32'h0);
    check("halt_no_req", n_req - n0, 0);
    step(1'b1, 32'h8000_0200);
    step(1'b0, 32'h0);
    check("resume_fire", last_req_fire, 1'b1);
    check("resume_addr", last_req_addr, 32'h8000_0200);

    // Bus error on the response for 0x80000008.
    err_addr_en = 1'b1; err_addr = 32'h8000_0008;
    step(1'b1, 32'h8000_0000);
    dq.delete(); seen = 1'b0;
    repeat (12) begin
      step(1'b0, 32'h0);
      if (last_dec_fire) dq.push_back(last_dec_pc);
      if (obs_acc) begin seen = 1'b1; check("err_fault_addr", obs_fault, 32'h8000_0008); end
    end
    err_addr_en = 1'b0;
    check("err_dec0", dq[0], 32'h8000_0000);
    check("err_dec1", dq[1], 32'h8000_0004);
    if (BUS_ERR_EN) begin
      check("err_pulse_seen", seen, 1'b1);
      check("err_halt_count", dq.size(), 2);
    end else begin
      check("err_pulse_seen", seen, 1'b0);
      check("err_ignored_dec2", dq[2], 32'h8000_0008);
    end

    // Randomized traffic.
    jmp_pct = 4; rdy_pct = 70; dec_pct = 70; lat_min = 1; lat_max = 3; err_pct = 5;
    step(1'b1, 32'h8000_0000);
    repeat (3000) step(1'b0, 32'h0);

    // Reset in the middle of traffic clears everything at once.
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check("midrst_dec_valid", dec_valid, 1'b0);
    check("midrst_req_valid", bus.req_valid, 1'b0);
    check("midrst_req_addr", bus.req_addr, BOOT);
    check("midrst_fault_addr", fault_addr, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (800) step(1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
